// File: rtl/cg_reg_bank_if.sv
// Bus bundle for cg_reg_bank: per-channel write enables and data in,
// registered data/pulse/gating-advice and saved-cycle count out.
//
// Timing contract: there is no back-pressure. The master drives en, d_in and
// clr_cnt, and the bank samples them at every rising clock edge. Each output
// is registered and reflects the inputs seen at the previous edge.
interface cg_reg_bank_if #(
    parameter int WIDTH = 8,
    parameter int N     = 2,
    parameter int CNT_W = 16
);
    logic [N-1:0]       en;
    logic [N*WIDTH-1:0] d_in;
    logic               clr_cnt;
    logic [N*WIDTH-1:0] d_out;
    logic [N-1:0]       upd;
    logic [N-1:0]       gate_req;
    logic [CNT_W-1:0]   saved_cnt;

    modport master (
        output en, d_in, clr_cnt,
        input  d_out, upd, gate_req, saved_cnt
    );

    modport slave (
        input  en, d_in, clr_cnt,
        output d_out, upd, gate_req, saved_cnt
    );
endinterface

// File: rtl/cg_reg_bank.sv
// Bank of N independent WIDTH-bit enabled registers. Each channel has
// optional write suppression for unchanged data and an idle detector that
// raises gate_req. A saturating counter accumulates gated channel-cycles.
// The parameters must match those of the connected cg_reg_bank_if.
module cg_reg_bank #(
    parameter int WIDTH       = 8,
    parameter int N           = 2,
    parameter int IDLE_THRESH = 3,
    parameter int DATA_DRIVEN = 1,
    parameter int CNT_W       = 16
) (
    input logic          clk,
    input logic          rst,
    cg_reg_bank_if.slave bus
);
    localparam int IW = $clog2(IDLE_THRESH + 1);
    localparam int PW = $clog2(N + 1);
    localparam int SW = CNT_W + PW;
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_THRESH);
    localparam logic [SW-1:0] CNT_MAX  = {{PW{1'b0}}, {CNT_W{1'b1}}};

    logic [N*WIDTH-1:0] data_q;
    logic [N-1:0]       upd_q;
    logic [N-1:0]       gate_q;
    logic [IW-1:0]      idle_q [N];
    logic [CNT_W-1:0]   cnt_q;
    logic [N-1:0]       wr;
    logic [PW-1:0]      gated_cnt;
    logic [SW-1:0]      cnt_sum;

    // Effective write: enable, and (in data-driven mode) a changed value.
    // gate_req is deliberately not part of this decision.
    always_comb begin
        wr = '0;
        for (int i = 0; i < N; i++) begin
            wr[i] = bus.en[i] &&
                    ((DATA_DRIVEN == 0) ||
                     (bus.d_in[i*WIDTH +: WIDTH] != data_q[i*WIDTH +: WIDTH]));
        end
    end

    // Per-channel data register, update pulse and idle/gating tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            upd_q  <= '0;
            gate_q <= '0;
            for (int i = 0; i < N; i++) begin
                idle_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (wr[i]) begin
                    data_q[i*WIDTH +: WIDTH] <= bus.d_in[i*WIDTH +: WIDTH];
                    upd_q[i]  <= 1'b1;
                    gate_q[i] <= 1'b0;
                    idle_q[i] <= '0;
                end else begin
                    upd_q[i] <= 1'b0;
                    // Idle count saturates at the threshold so it never wraps.
                    if (idle_q[i] != IDLE_MAX) begin
                        idle_q[i] <= idle_q[i] + 1'b1;
                    end
                    // Sticky once reached: idle_q stays at or above THRESH-1.
                    if ((int'(idle_q[i]) + 1) >= IDLE_THRESH) begin
                        gate_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Number of currently gated channels, added to the count with headroom.
    always_comb begin
        gated_cnt = '0;
        for (int i = 0; i < N; i++) begin
            gated_cnt = gated_cnt + PW'(gate_q[i]);
        end
        cnt_sum = SW'(cnt_q) + SW'(gated_cnt);
    end

    // Saturating saved-cycle counter; clear discards that cycle's increment.
    always_ff @(posedge clk) begin
        if (rst || bus.clr_cnt) begin
            cnt_q <= '0;
        end else if (cnt_sum > CNT_MAX) begin
            cnt_q <= '1;
        end else begin
            cnt_q <= cnt_sum[CNT_W-1:0];
        end
    end

    assign bus.d_out     = data_q;
    assign bus.upd       = upd_q;
    assign bus.gate_req  = gate_q;
    assign bus.saved_cnt = cnt_q;
endmodule

// File: tb/tb_cg_reg_bank.sv
// Bench for cg_reg_bank: three instances share one stimulus stream
// (data-driven/CNT_W=8, enable-only/CNT_W=8, data-driven/CNT_W=4) and are
// compared every cycle against a run-length behavioural model, plus
// directed literal checks.
module tb_cg_reg_bank;
    localparam int W  = 8;
    localparam int NC = 2;
    localparam int TH = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NC-1:0]   en      = '0;
    logic [NC*W-1:0] d_in    = '0;
    logic            clr_cnt = 1'b0;
    logic            chk_on  = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    cg_reg_bank_if #(.WIDTH(W), .N(NC), .CNT_W(8)) if0 ();
    cg_reg_bank_if #(.WIDTH(W), .N(NC), .CNT_W(8)) if1 ();
    cg_reg_bank_if #(.WIDTH(W), .N(NC), .CNT_W(4)) if2 ();

    assign if0.en = en;  assign if0.d_in = d_in;  assign if0.clr_cnt = clr_cnt;
    assign if1.en = en;  assign if1.d_in = d_in;  assign if1.clr_cnt = clr_cnt;
    assign if2.en = en;  assign if2.d_in = d_in;  assign if2.clr_cnt = clr_cnt;

    cg_reg_bank #(.WIDTH(W), .N(NC), .IDLE_THRESH(TH), .DATA_DRIVEN(1), .CNT_W(8))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    cg_reg_bank #(.WIDTH(W), .N(NC), .IDLE_THRESH(TH), .DATA_DRIVEN(0), .CNT_W(8))
        dut1 (.clk(clk), .rst(rst), .bus(if1));
    cg_reg_bank #(.WIDTH(W), .N(NC), .IDLE_THRESH(TH), .DATA_DRIVEN(1), .CNT_W(4))
        dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic [NC*W-1:0] dut_dout [3];
    logic [NC-1:0]   dut_upd  [3];
    logic [NC-1:0]   dut_gate [3];
    logic [7:0]      dut_cnt  [3];
    assign dut_dout[0] = if0.d_out;  assign dut_upd[0] = if0.upd;
    assign dut_dout[1] = if1.d_out;  assign dut_upd[1] = if1.upd;
    assign dut_dout[2] = if2.d_out;  assign dut_upd[2] = if2.upd;
    assign dut_gate[0] = if0.gate_req;  assign dut_cnt[0] = if0.saved_cnt;
    assign dut_gate[1] = if1.gate_req;  assign dut_cnt[1] = if1.saved_cnt;
    assign dut_gate[2] = if2.gate_req;  assign dut_cnt[2] = {4'b0, if2.saved_cnt};

    // ---------------- behavioural model ----------------
    // Each channel is described by its stored value and the length of the
    // current run of non-write cycles; gated means the run reached TH.
    int m_q    [3][NC];
    int m_upd  [3][NC];
    int m_run  [3][NC];
    int m_cnt  [3];
    int dd_of  [3] = '{1, 0, 1};
    int cmax   [3] = '{255, 255, 15};

    function automatic int gated(input int run);
        return (run >= TH) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int ng;
            int dv;
            ng = 0;
            for (int c = 0; c < NC; c++) ng = ng + gated(m_run[k][c]);
            for (int c = 0; c < NC; c++) begin
                dv = int'(d_in[c*W +: W]);
                if (rst) begin
                    m_q[k][c] = 0; m_upd[k][c] = 0; m_run[k][c] = 0;
                end else if (en[c] && (dd_of[k] == 0 || dv != m_q[k][c])) begin
                    m_q[k][c] = dv; m_upd[k][c] = 1; m_run[k][c] = 0;
                end else begin
                    m_upd[k][c] = 0;
                    if (m_run[k][c] < 1000) m_run[k][c] = m_run[k][c] + 1;
                end
            end
            if (rst || clr_cnt) m_cnt[k] = 0;
            else if (m_cnt[k] + ng > cmax[k]) m_cnt[k] = cmax[k];
            else m_cnt[k] = m_cnt[k] + ng;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output of every instance against the model each cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                for (int c = 0; c < NC; c++) begin
                    check($sformatf("i%0d_dout%0d", k, c), 32'(dut_dout[k][c*W +: W]), 32'(m_q[k][c]));
                    check($sformatf("i%0d_upd%0d", k, c), 32'(dut_upd[k][c]), 32'(m_upd[k][c]));
                    check($sformatf("i%0d_gate%0d", k, c), 32'(dut_gate[k][c]), 32'(gated(m_run[k][c])));
                end
                check($sformatf("i%0d_cnt", k), 32'(dut_cnt[k]), 32'(m_cnt[k]));
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick(input logic r, input logic [1:0] e, input logic [7:0] a0,
                        input logic [7:0] a1, input logic c);
        rst = r; en = e; d_in = {a1, a0}; clr_cnt = c;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [7:0] a0, input logic [7:0] a1);
        for (int i = 0; i < n; i++) tick(1'b0, 2'b00, a0, a1, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        @(negedge clk);
        tick(1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
        chk_on = 1'b1;
        tick(1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
        check("rst_dout", 32'(if0.d_out), 32'h0000);
        check("rst_upd", 32'(if0.upd), 32'h0);
        check("rst_gate", 32'(if0.gate_req), 32'h0);
        check("rst_cnt", 32'(if0.saved_cnt), 32'h0);

        // first write and hold
        tick(1'b0, 2'b01, 8'h01, 8'h00, 1'b0);
        check("wr_dout0", 32'(if0.d_out[7:0]), 32'h01);
        check("wr_upd", 32'(if0.upd), 32'h1);
        tick(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        check("hold_upd", 32'(if0.upd), 32'h0);
        check("hold_dout0a", 32'(if0.d_out[7:0]), 32'h01);
        tick(1'b0, 2'b00, 8'h01, 8'h00, 1'b0);
        check("hold_dout0b", 32'(if0.d_out[7:0]), 32'h01);
        check("gate_first", 32'(if0.gate_req), 32'h2);

        // write on a gated channel is accepted at once
        tick(1'b0, 2'b10, 8'h01, 8'h0D, 1'b0);
        check("wr1_dout1", 32'(if0.d_out[15:8]), 32'h0D);
        check("wr1_upd", 32'(if0.upd), 32'h2);
        check("wr1_gate", 32'(if0.gate_req), 32'h1);
        idle(2, 8'h01, 8'h0D);
        check("regate_early", 32'(if0.gate_req), 32'h1);
        idle(1, 8'h01, 8'h0D);
        check("regate", 32'(if0.gate_req), 32'h3);

        // redundant writes
        tick(1'b0, 2'b01, 8'h03, 8'h0D, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 2'b01, 8'h03, 8'h0D, 1'b0);
            check("red_upd_dd1", 32'(if0.upd), 32'h0);
            check("red_upd_dd0", 32'(if1.upd), 32'h1);
            if (i == 2) check("red_gate_dd1", 32'(if0.gate_req), 32'h3);
        end
        check("red_gate_dd0", 32'(if1.gate_req), 32'h2);

        // saved counter and clear
        tick(1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
        idle(3, 8'h00, 8'h00);
        check("cnt_gate11", 32'(if0.gate_req), 32'h3);
        check("cnt_start", 32'(if0.saved_cnt), 32'd0);
        idle(5, 8'h00, 8'h00);
        check("cnt_10", 32'(if0.saved_cnt), 32'd10);
        check("model_cnt_10", 32'(m_cnt[0]), 32'd10);
        tick(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
        check("cnt_clr", 32'(if0.saved_cnt), 32'd0);
        idle(1, 8'h00, 8'h00);
        check("cnt_resume", 32'(if0.saved_cnt), 32'd2);

        // saturation on the 4-bit counter
        idle(6, 8'h00, 8'h00);
        check("sat_14", 32'(if2.saved_cnt), 32'd14);
        idle(1, 8'h00, 8'h00);
        check("sat_15", 32'(if2.saved_cnt), 32'd15);
        idle(1, 8'h00, 8'h00);
        check("sat_hold", 32'(if2.saved_cnt), 32'd15);
        tick(1'b0, 2'b01, 8'hFE, 8'h00, 1'b0);
        check("sat_wr_dout0", 32'(if2.d_out[7:0]), 32'hFE);
        idle(1, 8'hFE, 8'h00);
        check("sat_after_wr", 32'(if2.saved_cnt), 32'd15);
        check("wide_after_wr", 32'(if0.saved_cnt), 32'd21);
        check("model_wide", 32'(m_cnt[0]), 32'd21);

        // reset mid-operation discards a concurrent write
        idle(3, 8'hFE, 8'h00);
        check("pre_rst_gate", 32'(if0.gate_req), 32'h3);
        tick(1'b1, 2'b01, 8'h55, 8'h00, 1'b0);
        check("mid_rst_dout", 32'(if0.d_out), 32'h0000);
        check("mid_rst_upd", 32'(if0.upd), 32'h0);
        check("mid_rst_gate", 32'(if0.gate_req), 32'h0);
        check("mid_rst_cnt", 32'(if0.saved_cnt), 32'h0);

        // randomized traffic, small data range to provoke redundant writes
        for (int i = 0; i < 400; i++) begin
            logic [1:0] e;
            e[0] = ($urandom_range(0, 2) == 0);
            e[1] = ($urandom_range(0, 2) == 0);
            tick(($urandom_range(0, 63) == 0), e,
                 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                 ($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cg_reg_bank.md
Name: cg_reg_bank

Overview:
- Parametrised successor to the single 8-bit enabled register: N independent WIDTH-bit enabled data registers in one bank.
- Adds synchronous reset and optional data-driven enable, where a write of an unchanged value is suppressed.
- Each channel has an idle detector that raises a gating request after IDLE_THRESH consecutive non-write cycles.
- A saturating saved-cycle counter feeds the automatic clock-gating insertion flow and power reporting.

Parameters:
- WIDTH, 8: data width per channel.
- N, 2: number of channels.
- IDLE_THRESH, 3: consecutive non-write cycles before gate_req asserts. Legal range is at least 1.
- DATA_DRIVEN, 1: 1 means a write happens only when the enable is high and the input differs from the stored value. 0 means the enable alone controls writes.
- CNT_W, 16: width of saved_cnt.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  N  per-channel write enable; bit i belongs to channel i.
- d_in  input  N*WIDTH  channel i uses bits [i*WIDTH +: WIDTH].
- clr_cnt  input  1  synchronous clear of saved_cnt.
- d_out  output  N*WIDTH  registered channel data, same packing as d_in.
- upd  output  N  registered one-cycle pulse; high in the cycle in which the new d_out value first appears.
- gate_req  output  N  registered; high means channel i is idle and its register clock may be gated.
- saved_cnt  output  CNT_W  saturating count of channel-cycles during which gate_req was high.

Behaviour:
- Reset: when rst=1 at a clock edge, d_out=0, upd=0, gate_req=0, saved_cnt=0, and all idle counters=0. Reset overrides every other input, including a reset asserted mid-operation.
- Effective write: w[i] = en[i] && (DATA_DRIVEN==0 || d_in_i != d_out_i).
- Write, w[i]=1: at the edge, d_out_i <= d_in_i, upd[i] <= 1, idle_i <= 0 and gate_req[i] <= 0. Latency is one edge from input to d_out.
- No write, w[i]=0:
  - d_out_i holds its value and upd[i] <= 0.
  - idle_i increments, saturating at IDLE_THRESH.
  - gate_req[i] <= 1 when idle_i+1 >= IDLE_THRESH. gate_req therefore rises at the edge ending the IDLE_THRESH-th consecutive non-write cycle and stays high until a write.
- Idle counter width: $clog2(IDLE_THRESH+1). It must not wrap.
- Redundant write (DATA_DRIVEN=1, en=1, d_in equal to d_out): treated exactly as no write. upd stays 0 and the idle count continues.
- gate_req is advisory only. The data path must never depend on it, and a write while gate_req=1 is accepted at that same edge.
- saved_cnt update at each edge:
  - If clr_cnt=1: saved_cnt <= 0. Clear wins, and that cycle's increment is discarded.
  - Otherwise: saved_cnt <= min(saved_cnt + popcount(gate_req), 2^CNT_W - 1), using the registered gate_req values present before the edge.
- Channels are fully independent. Simultaneous writes on any subset of channels are all accepted in the same cycle.
- Outputs after reset and before any write: all zero. gate_req first rises at the IDLE_THRESH-th edge after rst deasserts, if no writes occur.

Test Plan:
All scenarios use WIDTH=8, N=2, IDLE_THRESH=3, DATA_DRIVEN=1, CNT_W=8 unless stated otherwise.
1. Reset and hold: hold rst=1 for 2 cycles, then deassert -> d_out=0x0000, upd=0, gate_req=00, saved_cnt=0. Then ch0 en=1, d=0x01 -> after one edge d_out0=0x01 and upd0=1 for exactly one cycle. Then en=0 with d=0x00, then d=0x01 -> d_out0 stays 0x01.
2. Idle detect: after reset, ch1 en=0 -> gate_req1=1 after the 3rd edge. Then ch1 en=1, d=0x0D -> at the next edge d_out1=0x0D, upd1=1 and gate_req1=0. gate_req1 re-asserts 3 edges after en returns to 0.
3. Redundant write: ch0 holds 0x03, then en0=1 with d=0x03 for 4 cycles -> upd0 stays 0 and gate_req0=1 after the 3rd edge. Repeat on a DATA_DRIVEN=0 instance -> upd0=1 every cycle and gate_req0 stays 0.
4. Saved counter and clear: both channels idle until gate_req=11, then hold 5 more cycles -> saved_cnt increases by 2 per edge to 10. Pulse clr_cnt for one cycle -> saved_cnt=0 at the next edge, then resumes counting by 2.
5. Saturation: CNT_W=4, both channels gated -> saved_cnt climbs 2, 4, ... 14, then 15 and holds at 15. Write ch0=0xFE -> increments drop to 1 per edge and saved_cnt still holds 15.
6. Reset mid-operation: with d_out0=0xFE, gate_req=11 and saved_cnt=9, assert rst for one cycle while en0=1, d=0x55 -> after that edge all outputs are 0 and the write is discarded.
